uart_baud_gen: RTL and testbench

//  Runtime-selectable UART baud/oversample tick generator; next generation of the fixed-divisor bps block.

---
 rtl/uart_baud_pkg.sv | 46 ++++
 rtl/uart_nco.sv | 41 ++++
 rtl/uart_baud_gen.sv | 141 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// ---------------------------------------------------------------------------
// uart_baud_pkg
// Shared definitions for the UART baud/oversample tick generator:
//   state_t    FSM encoding (IDLE / ARM / RUN)
//   baud_rate  baud_sel (0..7) -> baud rate in bit/s
//   calc_inc   phase increment = round(baud * os * 2^acc_w / clk_hz)
//   rate_err   selected rate cannot be produced (baud * os >= clk_hz / 2)
// ---------------------------------------------------------------------------
package uart_baud_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   function automatic longint unsigned baud_rate(input logic [2:0] sel);
      longint unsigned b;
      case (sel)
         3'd0:    b = 64'd9600;
         3'd1:    b = 64'd19200;
         3'd2:    b = 64'd38400;
         3'd3:    b = 64'd57600;
         3'd4:    b = 64'd115200;
         3'd5:    b = 64'd230400;
         3'd6:    b = 64'd460800;
         default: b = 64'd921600;
      endcase
      return b;
   endfunction

   // Rounded to nearest so the long-run rate error stays below half an LSB.
   function automatic longint unsigned calc_inc(input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned acc_w,
                                                input longint unsigned clk_hz);
      return (((baud * os) << acc_w) + (clk_hz / 2)) / clk_hz;
   endfunction

   function automatic logic rate_err(input longint unsigned baud,
                                     input longint unsigned os,
                                     input longint unsigned clk_hz);
      return (baud * os) >= (clk_hz / 2);
   endfunction

endpackage

// File: rtl/uart_nco.sv
// ---------------------------------------------------------------------------
// uart_nco
// Phase accumulator. Each enabled cycle adds inc to acc (mod 2^ACC_W); the
// carry out of that add is presented combinationally on carry so the parent
// can register it together with the strobes derived from it.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset (acc -> 0)
//   inc    in  phase increment
//   clear  in  force acc to 0 this cycle (dominates run)
//   run    in  accumulate this cycle
//   carry  out accumulator overflows at the coming edge
// ---------------------------------------------------------------------------
module uart_nco #(
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ACC_W-1:0] inc,
   input  logic             clear,
   input  logic             run,
   output logic             carry
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum   = {1'b0, acc} + {1'b0, inc};
   assign carry = run & ~clear & sum[ACC_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (run) begin
         acc <= sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Runtime-selectable UART tick generator. An NCO produces os_tick at
// OVERSAMPLE x baud; os_cnt divides it down to a mid-bit sample_tick and an
// end-of-bit bit_tick. All three strobes are registered and coincident.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous active-high reset
//   en           in  run request (low = idle, counters held at 0)
//   baud_sel     in  rate select 0..7 (9600 .. 921600), latched in ARM only
//   resync       in  realign phase to now (honoured in RUN only)
//   os_tick      out oversample tick
//   sample_tick  out bit-centre strobe
//   bit_tick     out bit-boundary strobe
//   busy         out FSM in ARM or RUN
//   cfg_err      out latched rate is unreachable at CLK_HZ
// ---------------------------------------------------------------------------
module uart_baud_gen
   import uart_baud_pkg::*;
#(
   parameter int          CLK_HZ      = 25_000_000,
   parameter int          ACC_W       = 24,
   parameter int          OVERSAMPLE  = 16,
   parameter logic [2:0]  DEFAULT_SEL = 3'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] baud_sel,
   input  logic       resync,
   output logic       os_tick,
   output logic       sample_tick,
   output logic       bit_tick,
   output logic       busy,
   output logic       cfg_err
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(OVERSAMPLE - 1);

   function automatic logic [8*ACC_W-1:0] build_inc();
      logic [8*ACC_W-1:0] t;
      t = '0;
      for (int i = 0; i < 8; i++) begin
         t[i*ACC_W +: ACC_W] = ACC_W'(calc_inc(baud_rate(3'(i)), 64'(OVERSAMPLE),
                                               ACC_W, 64'(CLK_HZ)));
      end
      return t;
   endfunction

   function automatic logic [7:0] build_err();
      logic [7:0] t;
      t = '0;
      for (int i = 0; i < 8; i++) begin
         t[i] = rate_err(baud_rate(3'(i)), 64'(OVERSAMPLE), 64'(CLK_HZ));
      end
      return t;
   endfunction

   localparam logic [8*ACC_W-1:0] INC_TABLE = build_inc();
   localparam logic [7:0]         ERR_TABLE = build_err();

   state_t           state, state_nxt;
   logic [2:0]       sel_q;
   logic [ACC_W-1:0] inc_q;
   logic [CNT_W-1:0] os_cnt;
   logic             nco_clear;
   logic             nco_run;
   logic             carry;

   uart_nco #(.ACC_W(ACC_W)) u_nco (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_q),
      .clear (nco_clear),
      .run   (nco_run),
      .carry (carry)
   );

   // Next state plus NCO control. Anything other than a clean RUN cycle
   // (en high, no resync) clears the phase, so leaving RUN or realigning
   // can never emit a tick on that edge.
   always_comb begin
      state_nxt = state;
      nco_clear = 1'b1;
      nco_run   = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = ARM;
         end
         ARM: begin
            state_nxt = en ? RUN : IDLE;
         end
         RUN: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (!resync) begin
               nco_clear = 1'b0;
               // inc_q is already 0 for an illegal rate; gating run as well
               // keeps the strobes dead even if the table entry were nonzero.
               nco_run   = ~ERR_TABLE[sel_q];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sel_q       <= DEFAULT_SEL;
         inc_q       <= '0;
         cfg_err     <= 1'b0;
         os_cnt      <= '0;
         os_tick     <= 1'b0;
         sample_tick <= 1'b0;
         bit_tick    <= 1'b0;
      end else begin
         state       <= state_nxt;
         os_tick     <= carry;
         sample_tick <= carry && (os_cnt == CNT_HALF_M1);
         bit_tick    <= carry && (os_cnt == CNT_LAST);

         if (state == ARM) begin
            sel_q   <= baud_sel;
            inc_q   <= ERR_TABLE[baud_sel] ? '0 : INC_TABLE[baud_sel*ACC_W +: ACC_W];
            cfg_err <= ERR_TABLE[baud_sel];
         end

         if (nco_clear) begin
            os_cnt <= '0;
         end else if (carry) begin
            os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] baud_sel;
   logic       resync;
   logic       os_tick;
   logic       sample_tick;
   logic       bit_tick;
   logic       busy;
   logic       cfg_err;

   int checks = 0;
   int errors = 0;

   uart_baud_gen dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .baud_sel    (baud_sel),
      .resync      (resync),
      .os_tick     (os_tick),
      .sample_tick (sample_tick),
      .bit_tick    (bit_tick),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      int         err;
      int         os_lo;     // os_tick spacing must be os_lo or os_lo+1
      int         bit_lo;    // bit_tick spacing must be bit_lo or bit_lo+1
      int         ncyc;
      int         min_bits;
   } vec_t;

   vec_t vecs [8];

   // measurement results
   int n_os, n_bit, n_samp, os_viol, bit_viol, phase_viol, orphan;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input int ncyc, input int os_lo, input int bit_lo);
      int last_os, last_bit, os_since_bit, d;
      bit seen_bit;
      n_os = 0; n_bit = 0; n_samp = 0; os_viol = 0; bit_viol = 0;
      phase_viol = 0; orphan = 0;
      last_os = -1; last_bit = -1; os_since_bit = 0; seen_bit = 0;
      for (int c = 0; c < ncyc; c++) begin
         tick();
         if ((sample_tick || bit_tick) && !os_tick) orphan++;
         if (os_tick) begin
            n_os++;
            if (last_os >= 0) begin
               d = c - last_os;
               if (d < os_lo || d > os_lo + 1) os_viol++;
            end
            last_os = c;
            if (bit_tick) begin
               n_bit++;
               if (last_bit >= 0) begin
                  d = c - last_bit;
                  if (d < bit_lo || d > bit_lo + 1) bit_viol++;
               end
               last_bit = c;
               seen_bit = 1;
               os_since_bit = 0;
            end else begin
               os_since_bit++;
               if (sample_tick) begin
                  n_samp++;
                  if (seen_bit && os_since_bit != 8) phase_viol++;
               end
            end
         end
      end
   endtask

   // en asserted just before edge 0; returns edge index of first strobes.
   task automatic first_latency(output int k_os, output int k_samp,
                                output int k_bit, output int b0);
      k_os = -1; k_samp = -1; k_bit = -1; b0 = -1;
      en = 1'b1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (k == 0) b0 = int'(busy);
         if (os_tick && k_os < 0) k_os = k;
         if (sample_tick && k_samp < 0) k_samp = k;
         if (bit_tick) begin
            k_bit = k;
            break;
         end
      end
   endtask

   task automatic restart(input logic [2:0] sel);
      en = 1'b0;
      tick();
      tick();
      baud_sel = sel;
      en = 1'b1;
      tick();   // IDLE -> ARM
      tick();   // ARM loads rate -> RUN
   endtask

   initial begin
      int k_os, k_samp, k_bit, b0, span, cnt, nos, at_samp, at_bit;

      vecs[0] = '{3'd0, 0, 162, 2604, 8200, 3};
      vecs[1] = '{3'd1, 0,  81, 1302, 5500, 3};
      vecs[2] = '{3'd2, 0,  40,  651, 3000, 3};
      vecs[3] = '{3'd3, 0,  27,  434, 2000, 3};
      vecs[4] = '{3'd5, 0,   6,  108,  600, 3};
      vecs[5] = '{3'd6, 0,   3,   54,  400, 3};
      vecs[6] = '{3'd7, 1,   0,    0, 10000, 0};
      vecs[7] = '{3'd4, 0,  13,  217, 1200, 3};

      rst = 1'b1; en = 1'b0; baud_sel = 3'd4; resync = 1'b0;
      repeat (3) tick();
      chk("rst_os_tick", int'(os_tick), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();
      chk("idle_strobes", int'({os_tick, sample_tick, bit_tick}), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_cfg_err", int'(cfg_err), 0);

      // first-tick latency at 115200 (inc 1236951)
      first_latency(k_os, k_samp, k_bit, b0);
      chk("arm_busy", b0, 1);
      chk("first_os_edge", k_os, 15);
      chk("first_sample_edge", k_samp, 110);
      chk("first_bit_edge", k_bit, 219);

      // 100 bit periods measured from the first bit_tick
      span = -1; cnt = 0;
      for (int c = 1; c <= 23000; c++) begin
         tick();
         if (bit_tick) begin
            cnt++;
            if (cnt == 100) begin
               span = c;
               break;
            end
         end
      end
      chk_rng("span_100_bits", span, 21700, 21702);

      // rate table, including illegal sel 7 followed by recovery at sel 4
      foreach (vecs[i]) begin
         restart(vecs[i].sel);
         chk($sformatf("cfg_err_sel%0d", vecs[i].sel), int'(cfg_err), vecs[i].err);
         chk($sformatf("busy_sel%0d", vecs[i].sel), int'(busy), 1);
         measure(vecs[i].ncyc, vecs[i].os_lo, vecs[i].bit_lo);
         chk($sformatf("os_spacing_sel%0d", vecs[i].sel), os_viol, 0);
         chk($sformatf("bit_spacing_sel%0d", vecs[i].sel), bit_viol, 0);
         chk($sformatf("sample_phase_sel%0d", vecs[i].sel), phase_viol, 0);
         chk($sformatf("orphan_strobe_sel%0d", vecs[i].sel), orphan, 0);
         if (vecs[i].err != 0)
            chk($sformatf("no_ticks_sel%0d", vecs[i].sel), n_os, 0);
         else
            chk($sformatf("enough_bits_sel%0d", vecs[i].sel), int'(n_bit >= vecs[i].min_bits), 1);
      end

      // resync at os_cnt = 11 (still running sel 4)
      cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (bit_tick) break;
      end
      for (int c = 0; c < 1000 && cnt < 11; c++) begin
         tick();
         if (os_tick) cnt++;
      end
      chk("resync_setup_os", cnt, 11);
      resync = 1'b1;
      tick();
      resync = 1'b0;
      chk("resync_no_strobe", int'({os_tick, sample_tick, bit_tick}), 0);
      k_os = -1;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (os_tick) begin
            k_os = c;
            break;
         end
      end
      chk("resync_first_os", k_os, 14);
      nos = 1; at_samp = -1; at_bit = -1;
      if (sample_tick) at_samp = nos;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (os_tick) nos++;
         if (sample_tick && at_samp < 0) at_samp = nos;
         if (bit_tick) begin
            at_bit = nos;
            break;
         end
      end
      chk("resync_sample_after", at_samp, 8);
      chk("resync_bit_after", at_bit, 16);

      // baud_sel change during RUN is ignored until re-ARM
      baud_sel = 3'd1;
      measure(1200, 13, 217);
      chk("selchg_ignored_spacing", bit_viol, 0);
      chk("selchg_ignored_bits", int'(n_bit >= 3), 1);
      restart(3'd1);
      measure(5500, 81, 1302);
      chk("selchg_new_spacing", bit_viol, 0);
      chk("selchg_new_bits", int'(n_bit >= 3), 1);

      // en low together with resync: back to IDLE at once
      en = 1'b0;
      resync = 1'b1;
      tick();
      resync = 1'b0;
      chk("en_low_busy", int'(busy), 0);
      chk("en_low_strobes", int'({os_tick, sample_tick, bit_tick}), 0);

      // asynchronous reset while os_tick is high
      restart(3'd4);
      k_os = -1;
      for (int c = 0; c < 100; c++) begin
         if (os_tick) begin
            k_os = c;
            break;
         end
         tick();
      end
      chk("pre_rst_os_seen", int'(k_os >= 0), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_os_tick", int'(os_tick), 0);
      chk("async_rst_busy", int'(busy), 0);
      tick();
      rst = 1'b0;
      en = 1'b0;
      first_latency(k_os, k_samp, k_bit, b0);
      chk("post_rst_first_os", k_os, 15);
      chk("post_rst_first_bit", k_bit, 219);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
